// File: rtl/tap_fir_pkg.sv
// Shared constants for the time-shared 32-tap FIR multiply-accumulate.
package tap_fir_pkg;

  localparam int unsigned NTAPS = 32;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned ACCW  = 37;
  localparam int unsigned FRAC  = 15;
  localparam int unsigned IDXW  = $clog2(NTAPS);
  localparam int unsigned BUSW  = NTAPS * WIDTH;

  localparam logic signed [ACCW-1:0] ROUND_CONST = 37'sd16384;

  // Rounded-result limits before narrowing to the output width
  localparam logic signed [ACCW-1:0] R_HI = 37'sd32767;
  localparam logic signed [ACCW-1:0] R_LO = -37'sd32768;

  localparam logic [WIDTH-1:0] SAT_MAX     = 16'h7FFF;
  localparam logic [WIDTH-1:0] SAT_MIN     = 16'h8000;
  localparam logic [WIDTH-1:0] COEF0_RESET = 16'h7FFF;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] SAT  = 2'd2;

endpackage

// File: rtl/fir_coef_bank.sv
// Programmable coefficient register file; writes are locked out while a sample is in flight.
module fir_coef_bank
  import tap_fir_pkg::*;
(
  input  logic             clock,
  input  logic             aclr,
  input  logic             busy,
  input  logic             coef_we,
  input  logic [IDXW-1:0]  coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_data_c
);

  logic [WIDTH-1:0] coef [NTAPS];

  // Reset leaves a unity pass-through of tap 0
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        coef[i] <= (i == 0) ? COEF0_RESET : '0;
      end
    end else if (coef_we && !busy) begin
      coef[coef_addr] <= coef_data;
    end
  end

  assign rd_data_c = coef[rd_idx];

endmodule

// File: rtl/tap_fir_mac.sv
// 32-point FIR: one multiply-accumulate per cycle over captured taps, then round and saturate.
module tap_fir_mac
  import tap_fir_pkg::*;
(
  input  logic             clock,
  input  logic             aclr,
  input  logic             start,
  input  logic [BUSW-1:0]  taps,
  input  logic             coef_we,
  input  logic [IDXW-1:0]  coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic             overrun
);

  logic [1:0]              state, state_nxt;
  logic signed [ACCW-1:0]  acc, acc_nxt;
  logic [IDXW-1:0]         idx, idx_nxt;
  logic [WIDTH-1:0]        dout_nxt;
  logic                    valid_nxt, busy_nxt, overrun_nxt, cap_en_c;
  logic signed [WIDTH-1:0] tap_cap [NTAPS];
  logic signed [WIDTH-1:0] coef_c;
  logic signed [2*WIDTH-1:0] prod_c;
  logic signed [ACCW-1:0]  rnd_c, shr_c;
  logic [WIDTH-1:0]        sat_c;

  fir_coef_bank u_coef_bank (
    .clock     (clock),
    .aclr      (aclr),
    .busy      (busy),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .rd_idx    (idx),
    .rd_data_c (coef_c)
  );

  assign prod_c = coef_c * tap_cap[idx];

  // Round half up, arithmetic shift, clamp to the output range
  always_comb begin
    rnd_c = acc + ROUND_CONST;
    shr_c = rnd_c >>> FRAC;
    if (shr_c > R_HI) begin
      sat_c = SAT_MAX;
    end else if (shr_c < R_LO) begin
      sat_c = SAT_MIN;
    end else begin
      sat_c = shr_c[WIDTH-1:0];
    end
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    idx_nxt     = idx;
    dout_nxt    = dout;
    valid_nxt   = 1'b0;
    overrun_nxt = overrun;
    cap_en_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cap_en_c  = 1'b1;
          acc_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = MAC;
        end
      end
      MAC: begin
        acc_nxt = acc + ACCW'(prod_c);
        idx_nxt = idx + IDXW'(1);
        if (idx == IDXW'(NTAPS - 1)) begin
          state_nxt = SAT;
        end
      end
      SAT: begin
        dout_nxt  = sat_c;
        valid_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (start && (state != IDLE)) begin
      overrun_nxt = 1'b1;
    end
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      idx       <= idx_nxt;
      busy      <= busy_nxt;
      out_valid <= valid_nxt;
      dout      <= dout_nxt;
      overrun   <= overrun_nxt;
    end
  end

  // Snapshot the delay line so it may keep shifting during the computation
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        tap_cap[k] <= '0;
      end
    end else if (cap_en_c) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        tap_cap[k] <= taps[WIDTH*k +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_tap_fir_mac.sv
// Scoreboard bench for tap_fir_mac: directed samples queue expected results, a monitor checks them.
module tb_tap_fir_mac;

  logic         clock;
  logic         aclr;
  logic         start;
  logic [511:0] taps;
  logic         coef_we;
  logic [4:0]   coef_addr;
  logic [15:0]  coef_data;
  logic         busy;
  logic         out_valid;
  logic [15:0]  dout;
  logic         overrun;

  typedef struct {
    logic [15:0] d;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          n_vec;
  int          n_miss;

  tap_fir_mac dut (
    .clock     (clock),
    .aclr      (aclr),
    .start     (start),
    .taps      (taps),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy),
    .out_valid (out_valid),
    .dout      (dout),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dout", 32'(dout), 32'(e.d));
        check("latency_cycle", cyc, e.at);
      end
    end
  end

  function automatic logic [511:0] fill(input logic [15:0] v);
    logic [511:0] t;
    for (int k = 0; k < 32; k++) t[16*k +: 16] = v;
    return t;
  endfunction

  function automatic logic [511:0] rand_taps(input logic [15:0] t0);
    logic [511:0] t;
    for (int k = 0; k < 32; k++) t[16*k +: 16] = 16'($urandom);
    t[15:0] = t0;
    return t;
  endfunction

  // All tasks start and end at posedge+1
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [511:0] t, input bit expect_result, input logic [15:0] exp_d);
    taps  = t;
    start = 1'b1;
    if (expect_result) sb.push_back('{d: exp_d, at: cyc + 34});
    tick(1);
    start = 1'b0;
  endtask

  task automatic write_coef(input logic [4:0] a, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick(1);
    coef_we   = 1'b0;
  endtask

  task automatic write_all(input logic [15:0] d);
    for (int i = 0; i < 32; i++) write_coef(5'(i), d);
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    tick(2);
    aclr = 1'b0;
    tick(1);
  endtask

  int unsigned busy_cnt;
  int unsigned mark;

  initial begin
    n_vec = 0; n_miss = 0;
    aclr = 1'b1; start = 1'b0; taps = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    tick(3);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    aclr = 1'b0;
    tick(2);

    // Pass-through of tap 0 with reset coefficients; busy spans exactly 33 cycles
    pulse_start(rand_taps(16'h1234), 1'b1, 16'h1234);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy === 1'b1) busy_cnt++;
    end
    check("busy_cycles", busy_cnt, 32'd33);
    tick(2);

    // Write during MAC is dropped
    pulse_start(rand_taps(16'h1234), 1'b1, 16'h1234);
    tick(5);
    write_coef(5'd0, 16'h0000);
    tick(35);
    // Same write in IDLE takes effect
    write_coef(5'd0, 16'h0000);
    pulse_start(rand_taps(16'h1234), 1'b1, 16'h0000);
    tick(36);
    // Write and start together: new coefficient is used
    coef_we = 1'b1; coef_addr = 5'd0; coef_data = 16'h7FFF;
    pulse_start(rand_taps(16'h1234), 1'b1, 16'h1234);
    coef_we = 1'b0;
    tick(36);

    // Averaging filter
    write_all(16'h0400);
    pulse_start(fill(16'h1000), 1'b1, 16'h1000);
    tick(36);
    pulse_start(fill(16'hF000), 1'b1, 16'hF000);
    tick(36);

    // Output saturation both ways
    write_all(16'h7FFF);
    pulse_start(fill(16'h7FFF), 1'b1, 16'h7FFF);
    tick(36);
    pulse_start(fill(16'h8000), 1'b1, 16'h8000);
    tick(36);
    check("overrun_still_clear", 32'(overrun), 32'd0);

    // Overrun: second start ignored; start on out_valid cycle accepted
    do_reset();
    mark = cyc;
    pulse_start(rand_taps(16'h1234), 1'b1, 16'h1234);
    tick(9);
    pulse_start(rand_taps(16'h5555), 1'b0, 16'h0000);
    check("overrun_set", 32'(overrun), 32'd1);
    while (cyc < mark + 34) tick(1);
    check("out_valid_on_restart", 32'(out_valid), 32'd1);
    pulse_start(rand_taps(16'h0ABC), 1'b1, 16'h0ABC);
    tick(36);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Abort mid-MAC: no result, outputs and coefficients back to reset
    do_reset();
    write_coef(5'd0, 16'h4000);
    pulse_start(rand_taps(16'h1234), 1'b1, 16'h091A);
    tick(36);
    pulse_start(rand_taps(16'h2222), 1'b0, 16'h0000);
    tick(15);
    aclr = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dout", 32'(dout), 32'd0);
    check("abort_overrun", 32'(overrun), 32'd0);
    tick(2);
    aclr = 1'b0;
    tick(40);
    pulse_start(rand_taps(16'h1234), 1'b1, 16'h1234);
    tick(40);

    check("results_outstanding", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
